// File: rtl/linear_network_dispatch_fifo.sv
// Dispatch FIFO feeding a linear unicast network: buffers {dest, data} and issues one registered beat per cycle while enabled.
// Optional issue counter is enabled by defining LINEAR_DISPATCH_STATS_EN.
module linear_network_dispatch_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_NODE   = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int CMD_W     = (NUM_NODE > 1) ? $clog2(NUM_NODE) : 1,
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [CMD_W-1:0]      i_dest,
   output logic                  o_ready,
   input  logic                  i_en,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data_bus,
   output logic [CMD_W-1:0]      o_cmd,
   output logic [CNT_W-1:0]      o_count
`ifdef LINEAR_DISPATCH_STATS_EN
   ,
   output logic [15:0]           o_issue_cnt
`endif
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = CMD_W + DATA_WIDTH;

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head;

   // Full refuses a push even when a pop frees a slot in the same cycle.
   assign o_ready = (o_count != CNT_W'(FIFO_DEPTH));
   assign push    = i_valid && o_ready;
   assign pop     = i_en && (o_count != '0);
   assign head    = mem[rd_ptr];

   // NOTE: storage is not reset; occupancy and pointers alone define which entries are live.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= {i_dest, i_data};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_count    <= '0;
         o_valid    <= 1'b0;
         o_data_bus <= '0;
         o_cmd      <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   o_count <= o_count + CNT_W'(1);
            2'b01:   o_count <= o_count - CNT_W'(1);
            default: o_count <= o_count;
         endcase
         // Idle cycles emit an all-zero dummy beat.
         o_valid    <= pop;
         o_data_bus <= pop ? head[DATA_WIDTH-1:0] : '0;
         o_cmd      <= pop ? head[ENTRY_W-1:DATA_WIDTH] : '0;
      end
   end

`ifdef LINEAR_DISPATCH_STATS_EN
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         o_issue_cnt <= '0;
      end else if (pop && (o_issue_cnt != 16'hFFFF)) begin
         o_issue_cnt <= o_issue_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_linear_network_dispatch_fifo.sv
// Directed self-checking bench for linear_network_dispatch_fifo at default parameters.
// Issue-counter checks run only when LINEAR_DISPATCH_STATS_EN is defined.
module tb_linear_network_dispatch_fifo;

   logic       CLK;
   logic       rst;
   logic       i_valid;
   logic [7:0] i_data;
   logic [1:0] i_dest;
   logic       o_ready;
   logic       i_en;
   logic       o_valid;
   logic [7:0] o_data_bus;
   logic [1:0] o_cmd;
   logic [2:0] o_count;
`ifdef LINEAR_DISPATCH_STATS_EN
   logic [15:0] o_issue_cnt;
`endif

   int vectors;
   int miscompares;

   linear_network_dispatch_fifo #(
      .DATA_WIDTH(8),
      .NUM_NODE(4),
      .FIFO_DEPTH(4)
   ) dut (
      .CLK(CLK),
      .rst(rst),
      .i_valid(i_valid),
      .i_data(i_data),
      .i_dest(i_dest),
      .o_ready(o_ready),
      .i_en(i_en),
      .o_valid(o_valid),
      .o_data_bus(o_data_bus),
      .o_cmd(o_cmd),
      .o_count(o_count)
`ifdef LINEAR_DISPATCH_STATS_EN
      ,
      .o_issue_cnt(o_issue_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_beat(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
      check({tag, ".valid"}, 32'(o_valid), 32'(v));
      check({tag, ".data"},  32'(o_data_bus), 32'(d));
      check({tag, ".cmd"},   32'(o_cmd), 32'(c));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst     = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      i_dest  = '0;
      i_en    = 1'b0;
      tick();
      tick();

      // Reset state
      check_beat("rst", 1'b0, 8'h00, 2'd0);
      check("rst.count", 32'(o_count), 32'd0);
      check("rst.ready", 32'(o_ready), 32'd1);

      // Single push, minimum latency, following dummy beat
      rst     = 1'b0;
      i_en    = 1'b1;
      i_valid = 1'b1;
      i_dest  = 2'd2;
      i_data  = 8'hA5;
      tick();
      i_valid = 1'b0;
      check("lat.count1", 32'(o_count), 32'd1);
      check_beat("lat.c1", 1'b0, 8'h00, 2'd0);
      tick();
      check_beat("lat.c2", 1'b1, 8'hA5, 2'd2);
      check("lat.count0", 32'(o_count), 32'd0);
      tick();
      check_beat("lat.c3", 1'b0, 8'h00, 2'd0);

      // Fill with issue disabled; fifth push refused
      i_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         i_valid = 1'b1;
         i_data  = 8'h10 + 8'(k);
         i_dest  = 2'(k);
         tick();
         check("fill.count", 32'(o_count), (k < 4) ? 32'(k + 1) : 32'd4);
         check("fill.ready", 32'(o_ready), (k < 3) ? 32'd1 : 32'd0);
         check("fill.valid", 32'(o_valid), 32'd0);
      end
      i_valid = 1'b0;
      i_en    = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         check_beat("drain", 1'b1, 8'h10 + 8'(j), 2'(j));
         check("drain.count", 32'(o_count), 32'(3 - j));
      end
      tick();
      check_beat("drain.idle", 1'b0, 8'h00, 2'd0);

      // Full FIFO with push and pop both requested
      i_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         i_valid = 1'b1;
         i_data  = 8'h20 + 8'(k);
         i_dest  = 2'(k);
         tick();
      end
      check("full.count", 32'(o_count), 32'd4);
      i_en    = 1'b1;
      i_valid = 1'b1;
      i_data  = 8'h30;
      i_dest  = 2'd1;
      tick();
      check_beat("full.a", 1'b1, 8'h20, 2'd0);
      check("full.a.count", 32'(o_count), 32'd3);
      tick();
      check_beat("full.b", 1'b1, 8'h21, 2'd1);
      check("full.b.count", 32'(o_count), 32'd3);
      i_data = 8'h31;
      tick();
      check_beat("full.c", 1'b1, 8'h22, 2'd2);
      check("full.c.count", 32'(o_count), 32'd3);
      i_data = 8'h32;
      tick();
      check_beat("full.d", 1'b1, 8'h23, 2'd3);
      i_data = 8'h33;
      tick();
      check_beat("full.e", 1'b1, 8'h30, 2'd1);
      check("full.e.count", 32'(o_count), 32'd3);
      i_valid = 1'b0;
      tick();
      check_beat("full.f", 1'b1, 8'h31, 2'd1);
      tick();
      check_beat("full.g", 1'b1, 8'h32, 2'd1);
      tick();
      check_beat("full.h", 1'b1, 8'h33, 2'd1);
      check("full.h.count", 32'(o_count), 32'd0);
      tick();
      check_beat("full.idle", 1'b0, 8'h00, 2'd0);

      // Steady push plus pop across pointer wrap
      for (int k = 0; k < 10; k++) begin
         i_valid = 1'b1;
         i_data  = 8'h40 + 8'(k);
         i_dest  = 2'(k % 4);
         tick();
         check("steady.count", 32'(o_count), 32'd1);
         if (k == 0) check_beat("steady.first", 1'b0, 8'h00, 2'd0);
         else        check_beat("steady", 1'b1, 8'h40 + 8'(k - 1), 2'((k - 1) % 4));
      end
      i_valid = 1'b0;
      tick();
      check_beat("steady.last", 1'b1, 8'h49, 2'd1);
      check("steady.last.count", 32'(o_count), 32'd0);

      // Reset mid-operation with entries buffered and a beat in flight
      i_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_valid = 1'b1;
         i_data  = 8'h50 + 8'(k);
         i_dest  = 2'd3;
         tick();
      end
      i_valid = 1'b0;
      i_en    = 1'b1;
      tick();
      check_beat("mid.inflight", 1'b1, 8'h50, 2'd3);
      rst = 1'b1;
      #1;
      check_beat("mid.rst", 1'b0, 8'h00, 2'd0);
      check("mid.rst.count", 32'(o_count), 32'd0);
      check("mid.rst.ready", 32'(o_ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      check_beat("mid.after1", 1'b0, 8'h00, 2'd0);
      check("mid.after.count", 32'(o_count), 32'd0);
      tick();
      check_beat("mid.after2", 1'b0, 8'h00, 2'd0);

`ifdef LINEAR_DISPATCH_STATS_EN
      // Issue counter: six pops, then saturation
      check("stats.rst", 32'(o_issue_cnt), 32'd0);
      i_en    = 1'b1;
      i_valid = 1'b1;
      i_data  = 8'h60;
      for (int k = 0; k < 6; k++) tick();
      i_valid = 1'b0;
      tick();
      tick();
      check("stats.six", 32'(o_issue_cnt), 32'd6);
      i_valid = 1'b1;
      for (int k = 0; k < 65540; k++) tick();
      check("stats.sat", 32'(o_issue_cnt), 32'hFFFF);
      tick();
      check("stats.sat.hold", 32'(o_issue_cnt), 32'hFFFF);
      i_valid = 1'b0;
      tick();
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
